// File: rtl/cpu15_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu15_pkg
// Description : Shared definitions for the cpu15 core: opcode encodings,
//               the sequencer state encoding and the default width of the
//               retired-instruction counter.
// Revision    : 1.0  initial release
// ============================================================================
package cpu15_pkg;

  // Default width of the retired-instruction counter.
  localparam int CPU15_CNT_W = 16;

  // Opcode encodings. HLT stops the sequencer.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'ha;
  localparam logic [3:0] OP_JMP = 4'hb;
  localparam logic [3:0] OP_JZ  = 4'hc;
  localparam logic [3:0] OP_JC  = 4'hd;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  // Sequencer state encoding.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FT       = 3'd1,
    S_DC       = 3'd2,
    S_EX       = 3'd3,
    S_WB       = 3'd4,
    S_DBG      = 3'd5,
    S_DBG_WAIT = 3'd6
  } seq_state_e;

endpackage : cpu15_pkg
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_ctrl
// Description : Instruction sequencer for the cpu15 core. Steps the fetch,
//               decode, exec and writeback phases with one-hot enables, halts
//               on HLT, supports run / single-step control and hands RAM
//               ownership to a debug/loader port through a four-phase
//               REQ/ACK handshake while the core is halted.
//
// Ports       : CLK        system clock
//               RESET_N    asynchronous active-low reset
//               RUN        level, execute continuously
//               STEP       one-cycle pulse, execute one instruction when idle
//               OP_CODE    opcode from decode, valid during DC
//               DBG_REQ    debug RAM-access request
//               DBG_ACK    debug access granted
//               RAM_SEL    debug port owns the RAM mux
//               EN_FT/DC/EX/WB  one-hot phase enables
//               HALTED     no instruction in flight
//               INSN_CNT   retired-instruction count (wraps)
//
// Build option: CPU_SEQ_BKPT_EN adds P_COUNT, BKPT_ADDR, BKPT_VALID inputs
//               and the BKPT_HIT output (instruction-address breakpoint).
//
// Revision    : 1.0  initial release
// ============================================================================
module cpu_seq_ctrl
  import cpu15_pkg::*;
#(
  parameter int         CNT_W    = CPU15_CNT_W,
  parameter logic [3:0] HLT_CODE = OP_HLT
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RUN,
  input  logic             STEP,
  input  logic [3:0]       OP_CODE,
  input  logic             DBG_REQ,
`ifdef CPU_SEQ_BKPT_EN
  input  logic [7:0]       P_COUNT,
  input  logic [7:0]       BKPT_ADDR,
  input  logic             BKPT_VALID,
  output logic             BKPT_HIT,
`endif
  output logic             DBG_ACK,
  output logic             RAM_SEL,
  output logic             EN_FT,
  output logic             EN_DC,
  output logic             EN_EX,
  output logic             EN_WB,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSN_CNT
);

  localparam logic [2:0] ST_IDLE     = S_IDLE;
  localparam logic [2:0] ST_FT       = S_FT;
  localparam logic [2:0] ST_DC       = S_DC;
  localparam logic [2:0] ST_EX       = S_EX;
  localparam logic [2:0] ST_WB       = S_WB;
  localparam logic [2:0] ST_DBG      = S_DBG;
  localparam logic [2:0] ST_DBG_WAIT = S_DBG_WAIT;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_step_mode;
  logic             w_step_mode_nxt;
  logic             r_hlt_lock;
  logic [3:0]       r_op_q;
  logic [CNT_W-1:0] r_cnt;

`ifdef CPU_SEQ_BKPT_EN
  logic             w_bkpt_match;
  logic             w_bkpt_set;
  logic             r_run_d;
  logic             r_bkpt_hit;

  assign w_bkpt_match = BKPT_VALID && (P_COUNT == BKPT_ADDR);
  assign BKPT_HIT     = r_bkpt_hit;
`endif

  assign INSN_CNT = r_cnt;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next          = r_state;
    w_step_mode_nxt = r_step_mode;
`ifdef CPU_SEQ_BKPT_EN
    w_bkpt_set      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (DBG_REQ) begin
          w_next = ST_DBG;
        end else if (RUN && !r_hlt_lock) begin
`ifdef CPU_SEQ_BKPT_EN
          // A breakpoint blocks free-running entry; a STEP in the same
          // cycle still executes the breakpointed instruction.
          if (!w_bkpt_match) begin
            w_next          = ST_FT;
            w_step_mode_nxt = 1'b0;
          end else if (STEP) begin
            w_next          = ST_FT;
            w_step_mode_nxt = 1'b1;
          end else begin
            w_bkpt_set      = 1'b1;
          end
`else
          w_next          = ST_FT;
          w_step_mode_nxt = 1'b0;
`endif
        end else if (STEP) begin
          w_next          = ST_FT;
          w_step_mode_nxt = 1'b1;
        end
      end
      ST_FT: w_next = ST_DC;
      ST_DC: w_next = ST_EX;
      ST_EX: w_next = ST_WB;
      ST_WB: begin
        if (r_op_q == HLT_CODE) begin
          w_next = ST_IDLE;
        end else if (r_step_mode || !RUN || DBG_REQ) begin
          // A pending debug request is picked up from IDLE next cycle.
          w_next = ST_IDLE;
`ifdef CPU_SEQ_BKPT_EN
        end else if (w_bkpt_match) begin
          w_next     = ST_IDLE;
          w_bkpt_set = 1'b1;
`endif
        end else begin
          w_next = ST_FT;
        end
      end
      ST_DBG: w_next = ST_DBG_WAIT;
      ST_DBG_WAIT: begin
        if (!DBG_REQ) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, flags, counter and registered output decodes. The outputs are
  // decoded from the next state so they line up with the state register and
  // clear together with it on an asynchronous reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_step_mode <= 1'b0;
      r_hlt_lock  <= 1'b0;
      r_op_q      <= 4'h0;
      r_cnt       <= '0;
      EN_FT       <= 1'b0;
      EN_DC       <= 1'b0;
      EN_EX       <= 1'b0;
      EN_WB       <= 1'b0;
      HALTED      <= 1'b1;
      RAM_SEL     <= 1'b0;
      DBG_ACK     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_step_mode <= w_step_mode_nxt;

      if (r_state == ST_DC) begin
        r_op_q <= OP_CODE;
      end

      if (r_state == ST_WB) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end

      // Lock is released only by RUN going low, so a held RUN cannot
      // restart the core after HLT.
      if ((r_state == ST_WB) && (r_op_q == HLT_CODE)) begin
        r_hlt_lock <= 1'b1;
      end else if (!RUN) begin
        r_hlt_lock <= 1'b0;
      end

      EN_FT   <= (w_next == ST_FT);
      EN_DC   <= (w_next == ST_DC);
      EN_EX   <= (w_next == ST_EX);
      EN_WB   <= (w_next == ST_WB);
      HALTED  <= (w_next == ST_IDLE) || (w_next == ST_DBG) ||
                 (w_next == ST_DBG_WAIT);
      RAM_SEL <= (w_next == ST_DBG) || (w_next == ST_DBG_WAIT);
      DBG_ACK <= (w_next == ST_DBG_WAIT);
    end
  end

`ifdef CPU_SEQ_BKPT_EN
  // Breakpoint flag: set on a blocked transition into FT, cleared by the
  // next STEP pulse or a falling edge of RUN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_run_d    <= 1'b0;
      r_bkpt_hit <= 1'b0;
    end else begin
      r_run_d <= RUN;
      if (w_bkpt_set) begin
        r_bkpt_hit <= 1'b1;
      end else if (STEP || (r_run_d && !RUN)) begin
        r_bkpt_hit <= 1'b0;
      end
    end
  end
`endif

endmodule : cpu_seq_ctrl
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cpu_seq_ctrl
// Description : Self-checking bench for cpu_seq_ctrl. Two instances share the
//               stimulus: a 16-bit counter build and a 4-bit counter build
//               (for counter wrap). Stimulus pushes the expected retire count
//               into a scoreboard; a monitor pops it on every EN_WB and checks
//               the phase sequence and the counters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_seq_ctrl;

  logic        CLK     = 1'b0;
  logic        RESET_N = 1'b0;
  logic        RUN     = 1'b0;
  logic        STEP    = 1'b0;
  logic        DBG_REQ = 1'b0;
  logic [3:0]  OP_CODE = 4'h1;

  logic        DBG_ACK, RAM_SEL, EN_FT, EN_DC, EN_EX, EN_WB, HALTED;
  logic [15:0] INSN_CNT;
  logic        DBG_ACK4, RAM_SEL4, EN_FT4, EN_DC4, EN_EX4, EN_WB4, HALTED4;
  logic [3:0]  INSN_CNT4;

  cpu_seq_ctrl #(.CNT_W(16), .HLT_CODE(4'hf)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .OP_CODE(OP_CODE),
    .DBG_REQ(DBG_REQ), .DBG_ACK(DBG_ACK), .RAM_SEL(RAM_SEL), .EN_FT(EN_FT),
    .EN_DC(EN_DC), .EN_EX(EN_EX), .EN_WB(EN_WB), .HALTED(HALTED),
    .INSN_CNT(INSN_CNT)
  );

  cpu_seq_ctrl #(.CNT_W(4), .HLT_CODE(4'hf)) u_dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .OP_CODE(OP_CODE),
    .DBG_REQ(DBG_REQ), .DBG_ACK(DBG_ACK4), .RAM_SEL(RAM_SEL4), .EN_FT(EN_FT4),
    .EN_DC(EN_DC4), .EN_EX(EN_EX4), .EN_WB(EN_WB4), .HALTED(HALTED4),
    .INSN_CNT(INSN_CNT4)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int m_cnt  = 0;
  int sb_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void exp_retire();
    m_cnt++;
    sb_q.push_back(m_cnt);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Returns at the first negedge where EN_FT is seen, bounded.
  task automatic wait_ft(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (EN_FT) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: every retire must follow FT,DC,EX,WB on consecutive cycles and
  // the counters must show the scoreboard value one cycle later.
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic [15:0] hist;
    int          exp_v;
    logic [31:0] exp_l;
    hist = '0;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        hist = {hist[11:0], EN_FT, EN_DC, EN_EX, EN_WB};
        if (EN_WB) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
          end else begin
            exp_v = sb_q.pop_front();
            exp_l = exp_v;
            chk("phase_seq", {16'd0, hist}, 32'h0000_8421);
            chk("wb4_align", {31'd0, EN_WB4}, 32'd1);
            @(negedge CLK);
            hist = {hist[11:0], EN_FT, EN_DC, EN_EX, EN_WB};
            chk("retire_cnt16", {16'd0, INSN_CNT}, {16'd0, exp_l[15:0]});
            chk("retire_cnt4", {28'd0, INSN_CNT4}, {28'd0, exp_l[3:0]});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int fts;

    // Reset state
    cyc(3);
    chk("rst_outs", {25'd0, DBG_ACK, RAM_SEL, EN_FT, EN_DC, EN_EX, EN_WB, HALTED},
        32'h01);
    chk("rst_outs4", {25'd0, DBG_ACK4, RAM_SEL4, EN_FT4, EN_DC4, EN_EX4, EN_WB4,
        HALTED4}, 32'h01);
    chk("rst_cnt", {16'd0, INSN_CNT}, 32'd0);
    RESET_N = 1'b1;
    cyc(2);
    chk("idle_after_rst", {31'd0, HALTED}, 32'd1);

    // 1: free run, three instructions back-to-back
    OP_CODE = 4'h1;
    exp_retire(); exp_retire(); exp_retire();
    RUN = 1'b1;
    wait_ft("t1_ft_seen");
    cyc(1);
    chk("t1_dc_onehot", {28'd0, EN_FT, EN_DC, EN_EX, EN_WB}, 32'h4);
    cyc(7);
    chk("t1_ft3_cadence", {31'd0, EN_FT}, 32'd1);
    RUN = 1'b0;
    cyc(4);
    chk("t1_cnt3", {16'd0, INSN_CNT}, 32'd3);
    chk("t1_halted", {28'd0, EN_FT, EN_DC, EN_EX, HALTED}, 32'h1);

    // 2: HLT, lock with RUN held, STEP while locked, RUN re-rise restart
    OP_CODE = 4'hf;
    exp_retire();
    RUN = 1'b1;
    wait_ft("t2_ft_seen");
    cyc(4);
    chk("t2_hlt_halted", {31'd0, HALTED}, 32'd1);
    chk("t2_hlt_cnt", {16'd0, INSN_CNT}, 32'd4);
    fts = 0;
    repeat (10) begin
      cyc(1);
      if (EN_FT) fts++;
    end
    chk("t2_locked_no_ft", fts, 32'd0);
    OP_CODE = 4'h1;
    exp_retire();
    STEP = 1'b1;
    cyc(1);
    STEP = 1'b0;
    chk("t2_step_locked", {31'd0, EN_FT}, 32'd1);
    cyc(4);
    chk("t2_step_cnt", {16'd0, INSN_CNT}, 32'd5);
    cyc(5);
    chk("t2_still_locked", {31'd0, HALTED}, 32'd1);
    RUN = 1'b0;
    cyc(1);
    RUN = 1'b1;
    exp_retire();
    wait_ft("t2_restart");
    RUN = 1'b0;
    cyc(4);
    chk("t2_restart_cnt", {16'd0, INSN_CNT}, 32'd6);

    // 3: two STEP pulses 10 cycles apart; a pulse mid-instruction is dropped
    exp_retire(); exp_retire();
    STEP = 1'b1;
    cyc(1);
    STEP = 1'b0;
    chk("t3_step1_ft", {31'd0, EN_FT}, 32'd1);
    cyc(1);
    STEP = 1'b1;
    cyc(1);
    STEP = 1'b0;
    cyc(2);
    chk("t3_between_halted", {31'd0, HALTED}, 32'd1);
    chk("t3_cnt7", {16'd0, INSN_CNT}, 32'd7);
    cyc(5);
    STEP = 1'b1;
    cyc(1);
    STEP = 1'b0;
    chk("t3_step2_ft", {31'd0, EN_FT}, 32'd1);
    cyc(4);
    chk("t3_cnt8", {16'd0, INSN_CNT}, 32'd8);
    cyc(3);
    chk("t3_idle_after", {31'd0, HALTED}, 32'd1);

    // 4: debug request during EX of a running instruction
    RUN = 1'b1;
    exp_retire();
    wait_ft("t4_ft_seen");
    cyc(2);
    DBG_REQ = 1'b1;
    cyc(2);
    chk("t4_after_wb", {29'd0, HALTED, RAM_SEL, DBG_ACK}, 32'h4);
    chk("t4_cnt9", {16'd0, INSN_CNT}, 32'd9);
    cyc(1);
    chk("t4_ramsel", {30'd0, RAM_SEL, DBG_ACK}, 32'h2);
    cyc(1);
    chk("t4_ack", {30'd0, RAM_SEL, DBG_ACK}, 32'h3);
    cyc(3);
    chk("t4_ack_hold", {29'd0, HALTED, RAM_SEL, DBG_ACK}, 32'h7);
    DBG_REQ = 1'b0;
    exp_retire();
    cyc(1);
    chk("t4_release", {30'd0, RAM_SEL, DBG_ACK}, 32'h0);
    cyc(1);
    chk("t4_resume_ft", {31'd0, EN_FT}, 32'd1);
    RUN = 1'b0;
    cyc(4);
    chk("t4_cnt10", {16'd0, INSN_CNT}, 32'd10);

    // 5: asynchronous reset during EX aborts the instruction
    RUN = 1'b1;
    wait_ft("t5_ft_seen");
    cyc(2);
    chk("t5_in_ex", {31'd0, EN_EX}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t5_async_outs", {25'd0, DBG_ACK, RAM_SEL, EN_FT, EN_DC, EN_EX, EN_WB,
        HALTED}, 32'h01);
    chk("t5_async_cnt", {16'd0, INSN_CNT}, 32'd0);
    m_cnt = 0;
    RUN = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    cyc(4);
    chk("t5_post_cnt", {16'd0, INSN_CNT}, 32'd0);
    chk("t5_post_cnt4", {28'd0, INSN_CNT4}, 32'd0);

    // 6: 17 instructions; the 4-bit counter wraps to 1
    OP_CODE = 4'h3;
    for (int i = 0; i < 17; i++) exp_retire();
    RUN = 1'b1;
    wait_ft("t6_ft_seen");
    cyc(64);
    chk("t6_ft17", {31'd0, EN_FT}, 32'd1);
    RUN = 1'b0;
    cyc(4);
    chk("t6_cnt16", {16'd0, INSN_CNT}, 32'd17);
    chk("t6_cnt4_wrap", {28'd0, INSN_CNT4}, 32'd1);

    cyc(3);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_cpu_seq_ctrl
`default_nettype wire
